// File: rtl/psc_channel_array.sv
// Multi-lane parallel/serial converter with one shared IDLE/SHIFT/DONE controller.
// Each lane moves a WORD_LENGTH word as WORD_LENGTH/SERIAL_WIDTH serial beats.
module psc_channel_array #(
  parameter int NUM_CHANNELS = 4,
  parameter int WORD_LENGTH  = 32,
  parameter int SERIAL_WIDTH = 8,
  parameter bit MSB_FIRST    = 1'b0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [1:0]                           mode,
  input  logic                                 start,
  input  logic [NUM_CHANNELS-1:0]              channel_en,
  output logic                                 busy,
  output logic                                 finish,
  input  logic [SERIAL_WIDTH*NUM_CHANNELS-1:0] serial_data_in,
  input  logic [WORD_LENGTH*NUM_CHANNELS-1:0]  parallel_data_in,
  output logic [SERIAL_WIDTH*NUM_CHANNELS-1:0] serial_data_out,
  output logic [NUM_CHANNELS-1:0]              serial_valid,
  output logic [WORD_LENGTH*NUM_CHANNELS-1:0]  parallel_data_out,
  output logic [NUM_CHANNELS-1:0]              parallel_valid
);

  localparam int BEATS = WORD_LENGTH / SERIAL_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q;
  logic [1:0]                mode_q;
  logic [NUM_CHANNELS-1:0]   en_q;
  logic                      accept;

  logic [WORD_LENGTH-1:0]    word_q   [NUM_CHANNELS];
  logic [WORD_LENGTH-1:0]    asm_q    [NUM_CHANNELS];
  logic [WORD_LENGTH-1:0]    asm_next [NUM_CHANNELS];
  logic [SERIAL_WIDTH-1:0]   ser_q    [NUM_CHANNELS];
  logic [WORD_LENGTH-1:0]    par_q    [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]   ser_vld;
  logic [NUM_CHANNELS-1:0]   par_vld;

  // Beat k of the transfer maps to word slot k, or mirrored when MSB goes first.
  function automatic logic [CNT_W-1:0] slot(input logic [CNT_W-1:0] k);
    return MSB_FIRST ? (LAST - k) : k;
  endfunction

  function automatic logic [SERIAL_WIDTH-1:0] get_beat(input logic [WORD_LENGTH-1:0] w,
                                                       input logic [CNT_W-1:0] k);
    logic [SERIAL_WIDTH-1:0] r;
    r = '0;
    for (int j = 0; j < BEATS; j++)
      if (slot(k) == CNT_W'(j)) r = w[SERIAL_WIDTH*j +: SERIAL_WIDTH];
    return r;
  endfunction

  function automatic logic [WORD_LENGTH-1:0] put_beat(input logic [WORD_LENGTH-1:0] w,
                                                      input logic [CNT_W-1:0] k,
                                                      input logic [SERIAL_WIDTH-1:0] b);
    logic [WORD_LENGTH-1:0] r;
    r = w;
    for (int j = 0; j < BEATS; j++)
      if (slot(k) == CNT_W'(j)) r[SERIAL_WIDTH*j +: SERIAL_WIDTH] = b;
    return r;
  endfunction

  assign accept = (state_q == IDLE) && start && (mode != 2'b00) && (|channel_en);
  assign busy   = (state_q != IDLE);
  assign finish = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= 2'b00;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mode_q <= mode;
        en_q   <= channel_en;
        cnt_q  <= '0;
      end else if (state_q == SHIFT) begin
        cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
    end
  end

  // Receive side: mode 10 takes beats from the pins, loopback from its own serial output.
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++)
      asm_next[i] = put_beat(asm_q[i], cnt_q,
                             mode_q[0] ? ser_q[i] : serial_data_in[SERIAL_WIDTH*i +: SERIAL_WIDTH]);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (accept) word_q[i] <= parallel_data_in[WORD_LENGTH*i +: WORD_LENGTH];
      if (state_q == SHIFT && mode_q[1]) asm_q[i] <= asm_next[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ser_vld <= '0;
      par_vld <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        ser_q[i] <= '0;
        par_q[i] <= '0;
      end
    end else begin
      par_vld <= '0;
      if (accept) begin
        ser_vld <= mode[0] ? channel_en : '0;
        for (int i = 0; i < NUM_CHANNELS; i++)
          ser_q[i] <= (mode[0] && channel_en[i])
                      ? get_beat(parallel_data_in[WORD_LENGTH*i +: WORD_LENGTH], '0) : '0;
      end else if (state_q == SHIFT) begin
        if (cnt_q == LAST) begin
          ser_vld <= '0;
          for (int i = 0; i < NUM_CHANNELS; i++) begin
            ser_q[i] <= '0;
            if (mode_q[1] && en_q[i]) begin
              par_q[i]   <= asm_next[i];
              par_vld[i] <= 1'b1;
            end
          end
        end else begin
          for (int i = 0; i < NUM_CHANNELS; i++)
            ser_q[i] <= (mode_q[0] && en_q[i]) ? get_beat(word_q[i], cnt_q + 1'b1) : '0;
        end
      end
    end
  end

  always_comb begin
    serial_data_out   = '0;
    parallel_data_out = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      serial_data_out[SERIAL_WIDTH*i +: SERIAL_WIDTH] = ser_q[i];
      parallel_data_out[WORD_LENGTH*i +: WORD_LENGTH] = par_q[i];
    end
  end

  assign serial_valid   = ser_vld;
  assign parallel_valid = par_vld;

endmodule

// File: tb/tb_psc_channel_array.sv
// Bench for psc_channel_array: an LSB-first and an MSB-first instance share all inputs
// and are checked against word/beat arithmetic kept in the bench.
module tb_psc_channel_array;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   mode;
  logic         start;
  logic [3:0]   channel_en;
  logic [31:0]  serial_data_in;
  logic [127:0] parallel_data_in;

  logic         busy0, finish0, busy1, finish1;
  logic [31:0]  sout0, sout1;
  logic [3:0]   svld0, svld1, pvld0, pvld1;
  logic [127:0] pout0, pout1;

  int tests = 0;
  int fails = 0;

  logic [31:0] par_model0 [4];
  logic [31:0] par_model1 [4];

  always #5 clk = ~clk;

  psc_channel_array #(.NUM_CHANNELS(4), .WORD_LENGTH(32), .SERIAL_WIDTH(8), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .reset(reset), .mode(mode), .start(start), .channel_en(channel_en),
    .busy(busy0), .finish(finish0), .serial_data_in(serial_data_in),
    .parallel_data_in(parallel_data_in), .serial_data_out(sout0), .serial_valid(svld0),
    .parallel_data_out(pout0), .parallel_valid(pvld0));

  psc_channel_array #(.NUM_CHANNELS(4), .WORD_LENGTH(32), .SERIAL_WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .mode(mode), .start(start), .channel_en(channel_en),
    .busy(busy1), .finish(finish1), .serial_data_in(serial_data_in),
    .parallel_data_in(parallel_data_in), .serial_data_out(sout1), .serial_valid(svld1),
    .parallel_data_out(pout1), .parallel_valid(pvld1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " busy"}, {31'd0, busy0}, 32'd0);
    chk({tag, " finish"}, {31'd0, finish0}, 32'd0);
    chk({tag, " busy_msb"}, {31'd0, busy1}, 32'd0);
    chk({tag, " finish_msb"}, {31'd0, finish1}, 32'd0);
    chk({tag, " sout"}, sout0, 32'd0);
    chk({tag, " sout_msb"}, sout1, 32'd0);
    chk({tag, " vld"}, {24'd0, svld0, pvld0}, 32'd0);
    chk({tag, " vld_msb"}, {24'd0, svld1, pvld1}, 32'd0);
  endtask

  task automatic chk_par(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s pout lane%0d", tag, i), pout0[32*i +: 32], par_model0[i]);
      chk($sformatf("%s pout_msb lane%0d", tag, i), pout1[32*i +: 32], par_model1[i]);
    end
  endtask

  // One complete accepted transfer; sin_sel: 0 random beats, 1 0x10*i+k pattern, 2 all ones.
  task automatic run_xfer(input string tag, input logic [1:0] md, input logic [3:0] en,
                          input logic [127:0] pin, input int sin_sel, input bit junk);
    logic [31:0] asm0 [4];
    logic [31:0] asm1 [4];
    logic [7:0]  b;
    logic [7:0]  e0, e1;
    mode = md; channel_en = en; parallel_data_in = pin; start = 1'b1;
    tick();
    start = 1'b0;
    mode = 2'($urandom);
    channel_en = 4'($urandom);
    parallel_data_in = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 4; k++) begin
      if (junk && k == 1) begin
        start = 1'b1; mode = 2'b10; channel_en = 4'hF;
      end
      if (k == 2) start = 1'b0;
      for (int i = 0; i < 4; i++) begin
        case (sin_sel)
          1:       b = 8'(16 * i + k);
          2:       b = 8'hFF;
          default: b = 8'($urandom);
        endcase
        serial_data_in[8*i +: 8] = b;
        asm0[i][8*k +: 8]     = b;
        asm1[i][8*(3-k) +: 8] = b;
      end
      chk($sformatf("%s busy k%0d", tag, k), {30'd0, busy0, busy1}, 32'd3);
      chk($sformatf("%s finish k%0d", tag, k), {30'd0, finish0, finish1}, 32'd0);
      chk($sformatf("%s pvld k%0d", tag, k), {24'd0, pvld0, pvld1}, 32'd0);
      chk($sformatf("%s svld k%0d", tag, k), {24'd0, svld0, svld1},
          md[0] ? {24'd0, en, en} : 32'd0);
      for (int i = 0; i < 4; i++) begin
        e0 = (md[0] && en[i]) ? pin[32*i + 8*k +: 8] : 8'h00;
        e1 = (md[0] && en[i]) ? pin[32*i + 8*(3-k) +: 8] : 8'h00;
        chk($sformatf("%s sout k%0d lane%0d", tag, k, i), {24'd0, sout0[8*i +: 8]}, {24'd0, e0});
        chk($sformatf("%s sout_msb k%0d lane%0d", tag, k, i), {24'd0, sout1[8*i +: 8]}, {24'd0, e1});
      end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      if (md[1] && en[i]) begin
        par_model0[i] = md[0] ? pin[32*i +: 32] : asm0[i];
        par_model1[i] = md[0] ? pin[32*i +: 32] : asm1[i];
      end
    end
    chk({tag, " done busy"}, {30'd0, busy0, busy1}, 32'd3);
    chk({tag, " done finish"}, {30'd0, finish0, finish1}, 32'd3);
    chk({tag, " done svld"}, {24'd0, svld0, svld1}, 32'd0);
    chk({tag, " done sout"}, sout0 | sout1, 32'd0);
    chk({tag, " done pvld"}, {24'd0, pvld0, pvld1}, md[1] ? {24'd0, en, en} : 32'd0);
    chk_par({tag, " done"});
    tick();
    chk_idle_outputs({tag, " after"});
    chk_par({tag, " after"});
  endtask

  initial begin
    logic [127:0] pin;
    logic [3:0]   en;
    logic [1:0]   md;

    reset = 1'b0; mode = 2'b00; start = 1'b0; channel_en = 4'h0;
    serial_data_in = '0; parallel_data_in = '0;
    for (int i = 0; i < 4; i++) begin
      par_model0[i] = '0;
      par_model1[i] = '0;
    end
    tick(); tick();
    chk_idle_outputs("reset");
    chk_par("reset");
    reset = 1'b1;
    tick();

    // Directed P2S, lane 0 only, with a junk start mid-transfer.
    pin = {96'h0, 32'hA1B2C3D4} | {32'h11111111, 32'h22222222, 32'h33333333, 32'h0};
    run_xfer("p2s", 2'b01, 4'b0001, pin, 0, 1'b1);

    // Ignored starts in IDLE: mode 00, then no lanes enabled.
    mode = 2'b00; channel_en = 4'hF; start = 1'b1;
    tick();
    chk_idle_outputs("ign_mode0");
    mode = 2'b01; channel_en = 4'h0;
    tick();
    chk_idle_outputs("ign_en0");
    start = 1'b0;
    tick();
    chk_idle_outputs("ign_settle");
    chk_par("ign_settle");

    run_xfer("s2p_pat", 2'b10, 4'hF, {$urandom, $urandom, $urandom, $urandom}, 1, 1'b0);
    run_xfer("loop", 2'b11, 4'b0001, {96'h0, 32'hDEADBEEF}, 0, 1'b0);
    run_xfer("s2p_ones", 2'b10, 4'hF, '0, 2, 1'b0);
    run_xfer("s2p_0101", 2'b10, 4'b0101, '0, 0, 1'b0);

    // Reset two cycles into an S2P transfer discards everything.
    mode = 2'b10; channel_en = 4'hF; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      par_model0[i] = '0;
      par_model1[i] = '0;
    end
    chk_idle_outputs("midreset");
    chk_par("midreset");
    reset = 1'b1;
    tick();
    chk_idle_outputs("midreset_rel");
    run_xfer("post_reset", 2'b10, 4'hF, '0, 0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      md  = 2'($urandom_range(1, 3));
      en  = 4'($urandom_range(1, 15));
      pin = {$urandom, $urandom, $urandom, $urandom};
      run_xfer($sformatf("rnd%0d", n), md, en, pin, 0, 1'($urandom));
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/psc_channel_array.md
Name: psc_channel_array

Overview:
Parametrised multi-channel parallel/serial converter, the next-generation array stage of the PSC datapath. It converts NUM_CHANNELS words between WORD_LENGTH-bit parallel form and SERIAL_WIDTH-bit beats, using a single shared control FSM. Over the fixed-lane tile array, it adds:
- configurable serial beat width and bit order;
- per-channel enable;
- a loopback mode;
- explicit busy, valid and finish handshakes.

Parameters:
NUM_CHANNELS, 4, number of independent lanes.
WORD_LENGTH, 32, parallel word width per lane.
SERIAL_WIDTH, 8, bits per serial beat. Must divide WORD_LENGTH. BEATS = WORD_LENGTH/SERIAL_WIDTH, with BEATS >= 2.
MSB_FIRST, 0, 0 = least-significant beat first, 1 = most-significant beat first.

Ports:
clk  input  1  clock; all logic on rising edge.
reset  input  1  synchronous, active-low reset.
mode  input  2  00 idle/no-op, 01 parallel-to-serial (P2S), 10 serial-to-parallel (S2P), 11 loopback.
start  input  1  request, sampled only in IDLE.
channel_en  input  NUM_CHANNELS  per-lane enable, latched at start.
busy  output  1  high from the cycle after an accepted start through DONE.
finish  output  1  one-cycle pulse in DONE.
serial_data_in  input  SERIAL_WIDTH*NUM_CHANNELS  lane i at [SERIAL_WIDTH*i +: SERIAL_WIDTH].
parallel_data_in  input  WORD_LENGTH*NUM_CHANNELS  lane i at [WORD_LENGTH*i +: WORD_LENGTH].
serial_data_out  output  SERIAL_WIDTH*NUM_CHANNELS  registered beat per lane.
serial_valid  output  NUM_CHANNELS  per-lane beat-valid.
parallel_data_out  output  WORD_LENGTH*NUM_CHANNELS  registered assembled word per lane.
parallel_valid  output  NUM_CHANNELS  per-lane one-cycle pulse on word completion.

Behaviour:
- Reset (reset=0 at a clock edge):
  - FSM goes to IDLE and the beat counter is cleared.
  - All outputs go to 0: busy, finish, serial_data_out, serial_valid, parallel_data_out, parallel_valid.
  - Reset asserted mid-operation aborts the transfer. No finish is issued and partial data is discarded.
- FSM states are IDLE, SHIFT and DONE.
- IDLE to SHIFT:
  - Occurs when start=1, mode!=00 and channel_en!=0, sampled at cycle T.
  - At that edge the block latches mode and channel_en, and latches parallel_data_in into each lane's shift register.
  - Otherwise the FSM stays in IDLE. Start with mode=00 or channel_en=0 is ignored, with no finish.
- SHIFT occupies cycles T+1 .. T+BEATS; beat counter k = 0..BEATS-1.
  - Go to DONE when k = BEATS-1.
  - Start, mode and channel_en are ignored while busy.
- DONE occupies cycle T+BEATS+1, with finish=1. The FSM then returns to IDLE. The next start is accepted at T+BEATS+2 at the earliest.
- busy=1 in SHIFT and DONE.
- P2S (mode 01) and loopback (mode 11):
  - serial_data_out lane i carries beat k during cycle T+1+k.
  - Beat k is word bits [SERIAL_WIDTH*k +: SERIAL_WIDTH] when MSB_FIRST=0, else beat index BEATS-1-k.
  - serial_valid[i] = channel_en_latched[i] during SHIFT, else 0.
  - Disabled lanes drive serial_data_out = 0.
- S2P (mode 10):
  - The edge ending cycle T+1+k samples serial_data_in lane i as beat k, placed by the same ordering rule.
  - serial_data_out stays 0.
- Loopback (mode 11): each lane's serialized beats are reassembled internally. The result equals the latched parallel_data_in.
- Word completion (modes 10 and 11):
  - In DONE, parallel_data_out lane i is updated and parallel_valid[i]=1, for enabled lanes only.
  - Disabled lanes hold their previous parallel_data_out.
  - parallel_valid=0 in all other cycles and modes.
- P2S does not modify parallel_data_out.
- Latency:
  - P2S: first beat 1 cycle after start, finish BEATS+1 cycles after start.
  - S2P: word valid BEATS+1 cycles after start.
- Widths: lane slicing is fixed by lane index. No arithmetic other than the ceil-log2(BEATS)-bit beat counter.

Test Plan:
1. Defaults (WORD_LENGTH=32, SERIAL_WIDTH=8, MSB_FIRST=0), mode=01, channel_en=0001, lane0 = 0xA1B2C3D4, start at T -> lane0 serial beats D4, C3, B2, A1 with valid at T+1..T+4; finish and busy-end at T+5; lanes 1-3 serial_data_out = 0, valid = 0.
2. mode=10, channel_en=1111, lane i driven 0x10*i+{0,1,2,3} on beats 0..3 -> in DONE, lane i parallel_data_out = {0x10i+3, 0x10i+2, 0x10i+1, 0x10i}, parallel_valid = 1111 for one cycle.
3. MSB_FIRST=1 build, mode=11, lane0 = 0xDEADBEEF -> beats DE, AD, BE, EF, then parallel_data_out lane0 = 0xDEADBEEF with parallel_valid[0] pulse.
4. Second start at T+2 with different data, plus start with mode=00 in IDLE, and start with channel_en=0 -> all ignored: outputs unchanged from scenario 1, single finish.
5. reset=0 at T+2 of a mode-10 transfer -> next cycle busy = 0, all outputs 0, no finish; a fresh start then completes normally.
6. Mode 10 with channel_en=0101 after a prior all-lane word 0xFFFFFFFF -> lanes 1 and 3 retain 0xFFFFFFFF, lanes 0 and 2 update, parallel_valid = 0101.
